vga_timing_ctrl: RTL and testbench

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_axis_cnt.sv | 51 +++++
 rtl/vga_timing_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing controller: default 640x480@60
// timing, derived totals, counter width and the controller state encoding.
package vga_pkg;

  localparam int unsigned CNT_W   = 32'd10;
  localparam int unsigned CNT_MAX = 32'd1 << CNT_W;

  localparam int unsigned DEF_H_ACTIVE = 32'd640;
  localparam int unsigned DEF_H_FP     = 32'd16;
  localparam int unsigned DEF_H_SYNC   = 32'd96;
  localparam int unsigned DEF_H_BP     = 32'd48;
  localparam int unsigned DEF_V_ACTIVE = 32'd480;
  localparam int unsigned DEF_V_FP     = 32'd10;
  localparam int unsigned DEF_V_SYNC   = 32'd2;
  localparam int unsigned DEF_V_BP     = 32'd33;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } vga_state_e;

  // True when cnt lies in the inclusive window [lo, hi].
  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One scan axis counter: counts 0..TOTAL-1 on inc, wraps to 0, and flags
// the wrapping increment so the next axis can chain off it.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL = H_TOTAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 32'd1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(32'd1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A clear suppresses the wrap so a forced return to zero never chains.
  assign wrap = inc && !clr && (cnt_q == LAST);
  assign cnt  = cnt_q;

  // Next count: clear wins, then wrap-or-increment, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator. Counters advance on the external pixel
// enable; all outputs are registered from the next-state counter values so
// sync/de line up with x/y on the same clock.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p_tick,
  input  logic             en,
  output logic             h_sync,
  output logic             v_sync,
  output logic             de,
  output logic [CNT_W-1:0] x_pixel,
  output logic [CNT_W-1:0] y_pixel,
  output logic             frame_start,
  output logic             line_start,
  output logic             busy
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 32'd1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 32'd1);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 32'd1);
  localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_HI  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 32'd1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(32'd1);

  // Timing totals must fit the 10-bit scan counters.
  generate
    if ((H_TOT > CNT_MAX) || (V_TOT > CNT_MAX)) begin : g_size_check
      $error("vga_timing_ctrl: H/V totals exceed counter range");
    end
  endgenerate

  vga_state_e       state_q, state_d;
  logic             h_inc, cnt_clr, idle_start;
  logic [CNT_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic             h_wrap, v_wrap;
  logic             running;
  logic             hs_d, vs_d, de_d, fs_d, ls_d;
  logic             hs_q, vs_q, de_q, fs_q, ls_q;

  vga_axis_cnt #(.TOTAL(H_TOT)) u_h_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (h_inc),
    .clr   (cnt_clr),
    .cnt   (h_cnt),
    .wrap  (h_wrap)
  );

  vga_axis_cnt #(.TOTAL(V_TOT)) u_v_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (h_wrap),
    .clr   (cnt_clr),
    .cnt   (v_cnt),
    .wrap  (v_wrap)
  );

  // Controller next state and counter control; DRAIN exits only on the last pixel.
  always_comb begin
    state_d    = state_q;
    h_inc      = 1'b0;
    cnt_clr    = 1'b0;
    idle_start = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (p_tick && en) begin
          state_d    = RUN;
          idle_start = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        h_inc = p_tick;
        if (en) begin
          state_d = RUN;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (en) begin
          state_d = RUN;
          h_inc   = p_tick;
        end else if (p_tick && (h_cnt == H_LAST) && (v_cnt == V_LAST)) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else begin
          state_d = DRAIN;
          h_inc   = p_tick;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // Counter values after this edge, used to pre-decode the registered outputs.
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (cnt_clr) begin
      h_nxt = '0;
      v_nxt = '0;
    end else if (h_wrap) begin
      h_nxt = '0;
      if (v_wrap) begin
        v_nxt = '0;
      end else begin
        v_nxt = v_cnt + ONE;
      end
    end else if (h_inc) begin
      h_nxt = h_cnt + ONE;
    end else begin
      h_nxt = h_cnt;
      v_nxt = v_cnt;
    end
  end

  // Output decode from next-state position; pulses fire on entry and on wraps.
  always_comb begin
    running = (state_d != IDLE);
    if (running && in_window(h_nxt, HS_LO, HS_HI)) begin
      hs_d = SYNC_POL;
    end else begin
      hs_d = ~SYNC_POL;
    end
    if (running && in_window(v_nxt, VS_LO, VS_HI)) begin
      vs_d = SYNC_POL;
    end else begin
      vs_d = ~SYNC_POL;
    end
    de_d = running && (h_nxt < H_VIS) && (v_nxt < V_VIS);
    fs_d = idle_start || v_wrap;
    ls_d = idle_start || h_wrap;
  end

  // State and output registers with synchronous reset to the idle levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
    end
  end

  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;
  assign x_pixel     = h_cnt;
  assign y_pixel     = v_cnt;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl using a reduced raster (16x10
// totals) so whole frames fit in a short run. A reference model predicts
// every cycle's outputs into a queue that is popped after each edge.
module tb_vga_timing_ctrl;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic       clk = 1'b0;
  logic       reset, p_tick, en;
  logic       h_sync, v_sync, de, frame_start, line_start, busy;
  logic [9:0] x_pixel, y_pixel;

  always #5 clk = ~clk;

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .en(en),
    .h_sync(h_sync), .v_sync(v_sync), .de(de),
    .x_pixel(x_pixel), .y_pixel(y_pixel),
    .frame_start(frame_start), .line_start(line_start), .busy(busy)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  logic [25:0] exp_q[$];

  // reference model state: 0 idle, 1 run, 2 drain
  int m_st = 0, m_h = 0, m_v = 0;

  // window statistics over a span of p_tick edges
  bit win_on = 1'b0;
  int win_edges, win_de, win_hs, win_vs, win_fs, win_ls;
  bit last_p;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [25:0] model_step(input logic r, input logic p, input logic e);
    logic fs, ls, hs, vs, de_m, bz;
    bit last;
    fs = 1'b0;
    ls = 1'b0;
    if (r) begin
      m_st = 0; m_h = 0; m_v = 0;
    end else if (m_st == 0) begin
      if (p && e) begin
        m_st = 1; fs = 1'b1; ls = 1'b1;
      end
    end else begin
      last = (m_h == HT - 1) && (m_v == VT - 1);
      if (m_st == 2 && !e && p && last) begin
        m_st = 0; m_h = 0; m_v = 0;
      end else begin
        if (p) begin
          if (m_h == HT - 1) begin
            m_h = 0;
            ls  = 1'b1;
            if (m_v == VT - 1) begin
              m_v = 0;
              fs  = 1'b1;
            end else begin
              m_v = m_v + 1;
            end
          end else begin
            m_h = m_h + 1;
          end
        end
        m_st = e ? 1 : 2;
      end
    end
    hs   = !((m_h >= HA + HF) && (m_h <= HA + HF + HS - 1));
    vs   = !((m_v >= VA + VF) && (m_v <= VA + VF + VS - 1));
    de_m = (m_st != 0) && (m_h < HA) && (m_v < VA);
    bz   = (m_st != 0);
    return {bz, ls, fs, de_m, vs, hs, m_v[9:0], m_h[9:0]};
  endfunction

  task automatic step(input logic r, input logic p, input logic e);
    logic [25:0] obs;
    logic [25:0] expv;
    @(negedge clk);
    reset  = r;
    p_tick = p;
    en     = e;
    exp_q.push_back(model_step(r, p, e));
    @(posedge clk);
    #1;
    obs  = {busy, line_start, frame_start, de, v_sync, h_sync, y_pixel, x_pixel};
    expv = exp_q.pop_front();
    check("outputs", obs, expv);
    cyc++;
    last_p = p;
    if (p && win_on) begin
      win_edges++;
      if (de) win_de++;
      if (!h_sync) win_hs++;
      if (!v_sync) win_vs++;
      if (frame_start) win_fs++;
      if (line_start) win_ls++;
      if (win_edges == HT * VT) win_on = 1'b0;
    end
  endtask

  // mode 0: no p_tick, 1: one in four clocks, 2: every clock
  task automatic run(input int n, input int mode, input logic e);
    logic p;
    for (int i = 0; i < n; i++) begin
      if (mode == 2) p = 1'b1;
      else if (mode == 1) p = ((cyc % 4) == 0);
      else p = 1'b0;
      step(1'b0, p, e);
    end
  endtask

  task automatic goto_pos(input int hx, input int vy, input logic e);
    for (int i = 0; i < 4000; i++) begin
      if (m_h == hx && m_v == vy) break;
      run(1, 1, e);
    end
    check("goto_x", 32'(x_pixel), hx);
    check("goto_y", 32'(y_pixel), vy);
  endtask

  initial begin
    int drain_n;
    reset  = 1'b1;
    p_tick = 1'b0;
    en     = 1'b0;

    // reset regardless of p_tick/en
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);

    // idle: no en, then en without p_tick
    run(8, 1, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    // enter RUN on the first p_tick with en, then one full frame window
    run(4, 1, 1'b1);
    win_edges = 0; win_de = 0; win_hs = 0; win_vs = 0; win_fs = 0; win_ls = 0;
    win_on = 1'b1;
    run(HT * VT * 4, 1, 1'b1);
    check("win_edges", win_edges, HT * VT);
    check("frame_de", win_de, HA * VA);
    check("frame_hsync_low", win_hs, HS * VT);
    check("frame_vsync_low", win_vs, VS * HT);
    check("frame_starts", win_fs, 1);
    check("line_starts", win_ls, VT);

    // back-to-back p_tick, then a long stall with p_tick low
    run(40, 2, 1'b1);
    run(1000, 0, 1'b1);

    // en falls on the final-pixel edge: wrap, frame_start, full drain frame
    goto_pos(HT - 1, VT - 1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check("final_edge_fs", frame_start, 1);
    drain_n = 0;
    for (int i = 0; i < 3000 && busy; i++) begin
      run(1, 1, 1'b0);
      if (last_p && busy) drain_n++;
    end
    check("drain_edges", drain_n, HT * VT - 1);
    check("drain_idle_busy", busy, 0);

    // restart, drain from mid-frame, resume during drain, drain to idle
    run(8, 1, 1'b1);
    goto_pos(5, 3, 1'b1);
    run(20, 1, 1'b0);
    check("drain_busy", busy, 1);
    run(12, 1, 1'b1);
    for (int i = 0; i < 3000 && busy; i++) run(1, 1, 1'b0);
    check("idle_busy", busy, 0);
    check("idle_x", 32'(x_pixel), 0);
    check("idle_y", 32'(y_pixel), 0);

    // reset mid-frame aborts immediately
    run(8, 1, 1'b1);
    goto_pos(9, 5, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("rst_busy", busy, 0);
    check("rst_hsync", h_sync, 1);
    run(12, 1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
